// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Selects decode-operand forwarding, inserts load-use bubbles, and holds
// decode while the multi-cycle mul/div unit runs. Flushes IF/ID on taken
// branches and keeps a saturating count of stall cycles.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   d_*                    decode-stage instruction info
//   br_taken               branch/jump resolved taken in decode
//   e_rn/e_wreg/e_m2reg    execute-stage destination info
//   m_rn/m_wreg/m_m2reg    memory-stage destination info
//   fwda, fwdb             rs/rt operand select (00 rf, 01 exe, 10 mem alu, 11 mem load)
//   wpcir                  1 = PC and IF/ID advance, 0 = hold
//   de_bubble              D/E captures a bubble
//   fd_flush               IF/ID captures a NOP
//   md_busy, md_done       mul/div unit occupied / result-ready pulse
//   stall_cnt              saturating count of cycles with wpcir = 0
module pipe_hazard_ctrl #(
  parameter int unsigned MD_LAT = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             d_md,
  input  logic             br_taken,
  input  logic [4:0]       e_rn,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic [4:0]       m_rn,
  input  logic             m_wreg,
  input  logic             m_m2reg,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             de_bubble,
  output logic             fd_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MD_CW = $clog2(MD_LAT);
  localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

  md_state_t        state_q, state_d;
  logic [MD_CW-1:0] cnt_q, cnt_d;
  logic             lu;
  logic             md_accept;

  // Execute beats memory; register 0 never forwards; a load in execute
  // cannot forward (that case is the load-use stall).
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] ern, input logic ew, input logic em2,
    input logic [4:0] mrn, input logic mw, input logic mm2
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ew && (ern != 5'd0) && (ern == src) && !em2)
      sel = 2'b01;
    else if (mw && (mrn != 5'd0) && (mrn == src))
      sel = mm2 ? 2'b11 : 2'b10;
    return sel;
  endfunction

  // Load in execute whose result a source operand of decode needs.
  assign lu = d_valid && e_wreg && e_m2reg && (e_rn != 5'd0) &&
              ((d_use_rs && (e_rn == d_rs)) || (d_use_rt && (e_rn == d_rt)));

  // A mul/div op issues only when it is not itself held by a load-use stall.
  assign md_accept = d_valid && d_md && !lu;

  // Mul/div state and latency counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and pipeline control, in priority order.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fwda      = fwd_sel(d_rs, e_rn, e_wreg, e_m2reg, m_rn, m_wreg, m_m2reg);
    fwdb      = fwd_sel(d_rt, e_rn, e_wreg, e_m2reg, m_rn, m_wreg, m_m2reg);
    wpcir     = 1'b1;
    de_bubble = 1'b0;
    fd_flush  = 1'b0;
    md_busy   = 1'b0;
    md_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (md_accept) begin
          state_d = S_BUSY;
          cnt_d   = MD_LOAD;
        end
      end
      S_BUSY: begin
        md_busy = 1'b1;
        // Any valid younger instruction waits in decode.
        if (d_valid) begin
          wpcir     = 1'b0;
          de_bubble = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - MD_CW'(1);
        end
      end
      S_DONE: begin
        md_done = 1'b1;
        if (md_accept) begin
          state_d = S_BUSY;
          cnt_d   = MD_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (lu) begin
      wpcir     = 1'b0;
      de_bubble = 1'b1;
    end

    // A branch held by a stall flushes once decode is allowed to advance.
    fd_flush = d_valid && br_taken && wpcir;

    if (reset) begin
      fwda      = 2'b00;
      fwdb      = 2'b00;
      wpcir     = 1'b0;
      de_bubble = 1'b1;
      fd_flush  = 1'b0;
      md_busy   = 1'b0;
      md_done   = 1'b0;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!wpcir && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MD_LAT=4, CNT_W=4).
// The driver applies one directed vector per cycle and queues the
// hand-computed outputs; the monitor compares mid-cycle.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MD_LAT = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic             d_valid;
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic             d_use_rs;
  logic             d_use_rt;
  logic             d_md;
  logic             br_taken;
  logic [4:0]       e_rn;
  logic             e_wreg;
  logic             e_m2reg;
  logic [4:0]       m_rn;
  logic             m_wreg;
  logic             m_m2reg;
  logic [1:0]       fwda;
  logic [1:0]       fwdb;
  logic             wpcir;
  logic             de_bubble;
  logic             fd_flush;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .d_valid  (d_valid),
    .d_rs     (d_rs),
    .d_rt     (d_rt),
    .d_use_rs (d_use_rs),
    .d_use_rt (d_use_rt),
    .d_md     (d_md),
    .br_taken (br_taken),
    .e_rn     (e_rn),
    .e_wreg   (e_wreg),
    .e_m2reg  (e_m2reg),
    .m_rn     (m_rn),
    .m_wreg   (m_wreg),
    .m_m2reg  (m_m2reg),
    .fwda     (fwda),
    .fwdb     (fwdb),
    .wpcir    (wpcir),
    .de_bubble(de_bubble),
    .fd_flush (fd_flush),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .stall_cnt(stall_cnt)
  );

  // Expected vector layout: {fwda, fwdb, wpcir, de_bubble, fd_flush, md_busy, md_done, stall_cnt}
  typedef struct {
    string       nm;
    logic [12:0] v;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  always @(negedge clock) begin
    exp_t e;
    logic [12:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {fwda, fwdb, wpcir, de_bubble, fd_flush, md_busy, md_done, stall_cnt};
      checks = checks + 1;
      if (act !== e.v) begin
        errors = errors + 1;
        $display("FAIL %s: got fa=%b fb=%b wp=%b bub=%b fl=%b busy=%b done=%b cnt=%0d, want fa=%b fb=%b wp=%b bub=%b fl=%b busy=%b done=%b cnt=%0d",
                 e.nm, act[12:11], act[10:9], act[8], act[7], act[6], act[5], act[4], act[3:0],
                 e.v[12:11], e.v[10:9], e.v[8], e.v[7], e.v[6], e.v[5], e.v[4], e.v[3:0]);
      end
    end
  end

  task automatic set_d(input int v, input int rs, input int rt, input int urs,
                       input int urt, input int md, input int br);
    d_valid  = 1'(v);
    d_rs     = 5'(rs);
    d_rt     = 5'(rt);
    d_use_rs = 1'(urs);
    d_use_rt = 1'(urt);
    d_md     = 1'(md);
    br_taken = 1'(br);
  endtask

  task automatic set_e(input int rn, input int w, input int m2);
    e_rn    = 5'(rn);
    e_wreg  = 1'(w);
    e_m2reg = 1'(m2);
  endtask

  task automatic set_m(input int rn, input int w, input int m2);
    m_rn    = 5'(rn);
    m_wreg  = 1'(w);
    m_m2reg = 1'(m2);
  endtask

  // Queue this cycle's expected outputs, track stall_cnt, advance one cycle.
  task automatic cyc(input string nm, input int fa, input int fb, input int wp,
                     input int bub, input int fl, input int bz, input int dn);
    exp_t e;
    e.nm = nm;
    e.v  = {2'(fa), 2'(fb), 1'(wp), 1'(bub), 1'(fl), 1'(bz), 1'(dn), 4'(exp_cnt)};
    q.push_back(e);
    if (reset) exp_cnt = 0;
    else if (wp == 0 && exp_cnt < int'(CNT_MAX)) exp_cnt = exp_cnt + 1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_d(0, 0, 0, 0, 0, 0, 0);
    set_e(0, 0, 0);
    set_m(0, 0, 0);
    @(posedge clock);
    #1;
    exp_cnt = 0;

    // Reset masks forwarding and branch.
    set_d(1, 5, 5, 1, 1, 0, 1); set_e(5, 1, 0);
    cyc("reset", 0, 0, 0, 1, 0, 0, 0);
    reset = 1'b0;

    // Forwarding priority.
    set_d(1, 5, 0, 1, 0, 0, 0); set_e(5, 1, 0); set_m(5, 1, 0);
    cyc("fwd_e", 1, 0, 1, 0, 0, 0, 0);
    set_e(5, 0, 0);
    cyc("fwd_m", 2, 0, 1, 0, 0, 0, 0);
    set_m(5, 1, 1);
    cyc("fwd_mload", 3, 0, 1, 0, 0, 0, 0);
    set_d(1, 0, 0, 1, 0, 0, 0); set_e(0, 1, 0); set_m(0, 1, 0);
    cyc("fwd_r0", 0, 0, 1, 0, 0, 0, 0);
    set_d(1, 3, 9, 1, 1, 0, 0); set_e(9, 1, 0); set_m(9, 1, 0);
    cyc("fwdb_e_wins", 0, 1, 1, 0, 0, 0, 0);

    // Load-use.
    set_d(1, 0, 7, 0, 1, 0, 0); set_e(7, 1, 1); set_m(0, 0, 0);
    cyc("lu_stall", 0, 0, 0, 1, 0, 0, 0);
    set_e(0, 0, 0); set_m(7, 1, 1);
    cyc("lu_release", 0, 3, 1, 0, 0, 0, 0);
    set_d(1, 0, 7, 0, 0, 0, 0); set_e(7, 1, 1); set_m(0, 0, 0);
    cyc("lu_unused", 0, 0, 1, 0, 0, 0, 0);
    set_d(1, 0, 0, 0, 1, 0, 0); set_e(0, 1, 1);
    cyc("lu_r0", 0, 0, 1, 0, 0, 0, 0);
    set_d(0, 0, 7, 0, 1, 0, 0); set_e(7, 1, 1);
    cyc("lu_novalid", 0, 0, 1, 0, 0, 0, 0);
    set_d(1, 4, 0, 1, 0, 0, 0); set_e(4, 1, 1);
    cyc("lu_rs", 0, 0, 0, 1, 0, 0, 0);

    // Branch flush.
    set_e(0, 0, 0); set_d(1, 0, 0, 0, 0, 0, 1);
    cyc("br", 0, 0, 1, 0, 1, 0, 0);
    set_d(0, 0, 0, 0, 0, 0, 1);
    cyc("br_novalid", 0, 0, 1, 0, 0, 0, 0);
    set_d(1, 0, 7, 0, 1, 0, 1); set_e(7, 1, 1);
    cyc("br_lu", 0, 0, 0, 1, 0, 0, 0);
    set_e(0, 0, 0);
    cyc("br_after_lu", 0, 0, 1, 0, 1, 0, 0);

    // Single mul/div with a branch arriving during the busy window.
    set_d(1, 0, 0, 0, 0, 1, 0);
    cyc("md_issue", 0, 0, 1, 0, 0, 0, 0);
    set_d(1, 0, 0, 0, 0, 0, 0);
    cyc("md_busy1", 0, 0, 0, 1, 0, 1, 0);
    set_d(1, 0, 0, 0, 0, 0, 1);
    cyc("md_busy2_br", 0, 0, 0, 1, 0, 1, 0);
    cyc("md_busy3_br", 0, 0, 0, 1, 0, 1, 0);
    cyc("md_busy4_br", 0, 0, 0, 1, 0, 1, 0);
    cyc("md_done_br", 0, 0, 1, 0, 1, 0, 1);
    set_d(0, 0, 0, 0, 0, 0, 0);
    cyc("md_idle", 0, 0, 1, 0, 0, 0, 0);

    // Back-to-back mul/div accepted in the DONE cycle.
    set_d(1, 0, 0, 0, 0, 1, 0);
    cyc("b2b_issue", 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("b2b_wait", 0, 0, 0, 1, 0, 1, 0);
    cyc("b2b_accept", 0, 0, 1, 0, 0, 0, 1);
    set_d(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("b2b_busy_novalid", 0, 0, 1, 0, 0, 1, 0);
    cyc("b2b_done", 0, 0, 1, 0, 0, 0, 1);
    cyc("b2b_idle", 0, 0, 1, 0, 0, 0, 0);

    // Stall counter saturation (counter is 11 here).
    set_d(1, 0, 7, 0, 1, 0, 0); set_e(7, 1, 1);
    for (int i = 0; i < 5; i++) cyc("sat_lu", 0, 0, 0, 1, 0, 0, 0);
    set_e(0, 0, 0);
    cyc("sat_hold", 0, 0, 1, 0, 0, 0, 0);

    // Reset in the second BUSY cycle.
    set_d(1, 0, 0, 0, 0, 1, 0);
    cyc("rb_issue", 0, 0, 1, 0, 0, 0, 0);
    set_d(1, 0, 0, 0, 0, 0, 0);
    cyc("rb_busy1", 0, 0, 0, 1, 0, 1, 0);
    reset = 1'b1;
    cyc("rb_reset", 0, 0, 0, 1, 0, 0, 0);
    reset = 1'b0;
    cyc("rb_idle", 0, 0, 1, 0, 0, 0, 0);
    cyc("rb_no_done", 0, 0, 1, 0, 0, 0, 0);

    // A mul/div op hitting load-use retries the next cycle.
    set_d(1, 0, 7, 0, 1, 1, 0); set_e(7, 1, 1);
    cyc("md_lu_hold", 0, 0, 0, 1, 0, 0, 0);
    set_e(0, 0, 0);
    cyc("md_lu_issue", 0, 0, 1, 0, 0, 0, 0);
    set_d(1, 0, 0, 0, 0, 0, 0);
    cyc("md_lu_busy", 0, 0, 0, 1, 0, 1, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline. Drives the IF/ID and D/E pipeline registers.
- Selects operand forwarding for the decode-stage operands.
- Detects load-use hazards and inserts bubbles into the D/E register.
- Sequences the multi-cycle multiply/divide unit, holding younger instructions in decode until it finishes.
- Flushes IF/ID on taken branches/jumps and counts stall cycles for performance analysis.

Parameters:
- MD_LAT, 8: cycles the mul/div unit stays busy after issue; legal range 2..64.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- d_valid  in  1  decode stage holds a valid instruction.
- d_rs  in  5  decode source register rs.
- d_rt  in  5  decode source register rt.
- d_use_rs  in  1  decode instruction reads rs.
- d_use_rt  in  1  decode instruction reads rt.
- d_md  in  1  decode instruction is a mul/div op.
- br_taken  in  1  branch/jump resolved taken in decode.
- e_rn  in  5  execute-stage destination register.
- e_wreg  in  1  execute-stage register write enable.
- e_m2reg  in  1  execute-stage instruction is a load.
- m_rn  in  5  memory-stage destination register.
- m_wreg  in  1  memory-stage register write enable.
- m_m2reg  in  1  memory-stage instruction is a load.
- fwda  out  2  rs operand select.
- fwdb  out  2  rt operand select.
- wpcir  out  1  1 = PC and IF/ID advance; 0 = hold.
- de_bubble  out  1  1 = D/E register captures a bubble (wreg/wmem/m2reg/jal = 0).
- fd_flush  out  1  1 = IF/ID captures a NOP.
- md_busy  out  1  mul/div unit occupied.
- md_done  out  1  one-cycle pulse when the mul/div result is ready.
- stall_cnt  out  CNT_W  saturating count of cycles with wpcir=0.

Behaviour:
- Forwarding (combinational), applied to fwda/rs and fwdb/rt alike:
  - 01 when e_wreg, e_rn!=0, e_rn==src and !e_m2reg.
  - Otherwise 10 when m_wreg, m_rn!=0, m_rn==src and !m_m2reg.
  - Otherwise 11 when m_wreg, m_rn!=0, m_rn==src and m_m2reg.
  - Otherwise 00 (register file).
  - The execute stage always wins over memory. Register 0 never forwards.
- Load-use hazard lu: d_valid & e_wreg & e_m2reg & e_rn!=0 & ((d_use_rs & e_rn==d_rs) | (d_use_rt & e_rn==d_rt)).
- Mul/div FSM, state and counter registered:
  - IDLE: if d_valid & d_md & !lu, the op issues normally; next state BUSY, cnt <= MD_LAT-1.
  - BUSY: md_busy=1. If d_valid, then wpcir=0 and de_bubble=1, regardless of d_md. cnt decrements each cycle. When cnt==0, next state DONE.
  - DONE: md_done=1, md_busy=0, no md stall. A new md op accepted here goes directly to BUSY, cnt <= MD_LAT-1. Otherwise next state IDLE.
  - An md op that hits lu is not accepted; it is retried the next cycle.
- Priority, combinational outputs:
  1. reset: wpcir=0, de_bubble=1, fd_flush=0, fwda=fwdb=00, md_busy=0, md_done=0.
  2. BUSY stall.
  3. lu stall: wpcir=0, de_bubble=1 for exactly the cycle(s) in which lu holds.
  4. br_taken: fd_flush=1.
  5. Default: wpcir=1, de_bubble=0, fd_flush=0.
- fd_flush is asserted only when wpcir=1. A taken branch seen during a stall is re-evaluated once the stall releases.
- d_valid=0 never stalls and never flushes. In BUSY with d_valid=0, wpcir=1.
- stall_cnt increments on each cycle with wpcir=0 outside reset. It saturates at 2^CNT_W-1.
- Reset mid-BUSY: state to IDLE, cnt 0, stall_cnt 0, md_done not pulsed.
- Reset values of registered state: state IDLE, cnt 0, stall_cnt 0.

Test Plan:
- Forwarding: e_rn=5, e_wreg=1, e_m2reg=0, m_rn=5, m_wreg=1, d_rs=5 -> fwda=01. Then e_wreg=0 -> fwda=10. Then m_m2reg=1 -> fwda=11. Then d_rs=0 with all rn=0 -> fwda=00.
- Load-use: e_m2reg=1, e_rn=7, d_rt=7, d_use_rt=1 -> one cycle of wpcir=0, de_bubble=1, stall_cnt +1. Same case with d_use_rt=0 -> no stall.
- Mul/div with MD_LAT=4: md op issues at cycle 0 with wpcir=1. A younger valid instruction sees wpcir=0 for cycles 1..4. md_done pulses at cycle 5 with wpcir=1. stall_cnt=4.
- Back-to-back md: a second md op waiting in decode is accepted in the DONE cycle -> md_busy re-asserts the next cycle with no IDLE gap.
- Branch: br_taken=1 with no hazard -> fd_flush=1, wpcir=1. br_taken=1 during BUSY -> fd_flush=0 until the stall releases.
- Reset: reset pulsed in cycle 2 of BUSY -> next cycle state IDLE, md_busy=0, stall_cnt=0, no md_done. Force stall_cnt near max with CNT_W=4 -> holds at 15.
